// File: rtl/lsu_wb_master_if.sv
`default_nettype none
// ============================================================================
// Module   : lsu_wb_master_if
// Brief    : Wishbone bus bundle between the load/store unit master and a
//            single responder. Master drives cycle/strobe/address/data/select,
//            responder returns ack, stall and read data.
// Revision : 1.0 - initial release
// ============================================================================
interface lsu_wb_master_if #(
    parameter int ADDR_WIDTH = 10
);
    logic                  o_wb_cyc;
    logic                  o_wb_stb;
    logic                  o_wb_we;
    logic [ADDR_WIDTH-1:0] o_wb_addr;
    logic [31:0]           o_wb_data;
    logic [3:0]            o_wb_sel;
    logic                  i_wb_ack;
    logic                  i_wb_stall;
    logic [31:0]           i_wb_data;

    modport master (
        output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel,
        input  i_wb_ack, i_wb_stall, i_wb_data
    );

    modport slave (
        input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel,
        output i_wb_ack, i_wb_stall, i_wb_data
    );
endinterface
`default_nettype wire

// File: rtl/lsu_wb_master.sv
`default_nettype none
// ============================================================================
// Module   : lsu_wb_master
// Brief    : Load/store unit Wishbone master. Accepts one byte/half/word
//            access, places it on the bus with lane selects, and returns the
//            aligned, sign/zero-extended load result with a one-cycle done.
//            Optional macro LSU_MISALIGN_TRAP_EN: misaligned accesses are
//            trapped (o_err) instead of being aligned down.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_wb_master #(
    parameter int ADDR_WIDTH = 10
) (
    input  wire logic                  i_clk,
    input  wire logic                  i_rst_n,
    input  wire logic                  i_req,
    input  wire logic                  i_we,
    input  wire logic [2:0]            i_funct3,
    input  wire logic [ADDR_WIDTH-1:0] i_addr,
    input  wire logic [31:0]           i_wdata,
    output logic                       o_busy,
    output logic                       o_done,
    output logic [31:0]                o_rdata,
    output logic                       o_err,
    lsu_wb_master_if.master            wb
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        WAIT   = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;

    logic                  we_q;
    logic [2:0]            funct3_q;
    logic [1:0]            lo_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           data_q;
    logic [3:0]            sel_q;

    // Request decode: funct3[1:0] picks size, anything not B/H is a word.
    logic       is_byte;
    logic       is_half;
    logic [1:0] lo_eff;
    logic [3:0] sel_new;
    logic [31:0] data_new;
    logic       trap;
    logic       complete;
    logic [31:0] shifted;
    logic [31:0] load_val;

    assign is_byte = (i_funct3[1:0] == 2'b00);
    assign is_half = (i_funct3[1:0] == 2'b01);
    // Low address bits that matter for the size; the rest are aligned down.
    assign lo_eff  = is_byte ? i_addr[1:0] :
                     is_half ? {i_addr[1], 1'b0} : 2'b00;

`ifdef LSU_MISALIGN_TRAP_EN
    logic err_q;
    assign trap  = (is_half & i_addr[0]) | (~is_byte & ~is_half & (|i_addr[1:0]));
    assign o_err = err_q;
`else
    assign trap  = 1'b0;
    assign o_err = 1'b0;
`endif

    // Byte-lane selects and replicated write data for the accepted request.
    always_comb begin
        sel_new  = 4'b1111;
        data_new = i_wdata;
        if (is_byte) begin
            sel_new  = 4'b0001 << lo_eff;
            data_new = {4{i_wdata[7:0]}};
        end else if (is_half) begin
            sel_new  = 4'b0011 << lo_eff;
            data_new = {2{i_wdata[15:0]}};
        end
        if (!i_we) begin
            data_new = 32'h0;
        end
    end

    // Load extraction: shift the addressed lane down, then extend.
    assign shifted = wb.i_wb_data >> {lo_q, 3'b000};
    always_comb begin
        case (funct3_q[1:0])
            2'b00:   load_val = {{24{~funct3_q[2] & shifted[7]}}, shifted[7:0]};
            2'b01:   load_val = {{16{~funct3_q[2] & shifted[15]}}, shifted[15:0]};
            default: load_val = shifted;
        endcase
    end

    assign complete = ((state == STROBE) & ~wb.i_wb_stall & wb.i_wb_ack) |
                      ((state == WAIT) & wb.i_wb_ack);

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and bus control outputs.
    always_comb begin
        state_next  = state;
        o_busy      = (state != IDLE);
        wb.o_wb_cyc = (state != IDLE);
        wb.o_wb_stb = (state == STROBE);
        wb.o_wb_we  = we_q & (state != IDLE);
        case (state)
            IDLE: begin
                if (i_req && !trap) begin
                    state_next = STROBE;
                end
            end
            STROBE: begin
                if (!wb.i_wb_stall) begin
                    state_next = wb.i_wb_ack ? IDLE : WAIT;
                end
            end
            WAIT: begin
                if (wb.i_wb_ack) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Request capture, completion pulse and load result register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            lo_q     <= 2'b00;
            addr_q   <= '0;
            data_q   <= 32'h0;
            sel_q    <= 4'h0;
            o_done   <= 1'b0;
            o_rdata  <= 32'h0;
`ifdef LSU_MISALIGN_TRAP_EN
            err_q    <= 1'b0;
`endif
        end else begin
            o_done <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            err_q  <= 1'b0;
`endif
            if (state == IDLE && i_req) begin
                if (trap) begin
                    // Misaligned: report immediately, no bus cycle.
                    o_done <= 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
                    err_q  <= 1'b1;
`endif
                end else begin
                    we_q     <= i_we;
                    funct3_q <= i_funct3;
                    lo_q     <= lo_eff;
                    addr_q   <= {i_addr[ADDR_WIDTH-1:2], 2'b00};
                    data_q   <= data_new;
                    sel_q    <= sel_new;
                end
            end
            if (complete) begin
                o_done <= 1'b1;
                if (!we_q) begin
                    o_rdata <= load_val;
                end
            end
        end
    end

    assign wb.o_wb_addr = addr_q;
    assign wb.o_wb_data = data_q;
    assign wb.o_wb_sel  = sel_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_wb_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_wb_master
// Brief    : Directed self-checking bench for lsu_wb_master. A small
//            responder in run_access acks one cycle after an unstalled
//            strobe (or in the strobe cycle on request) and records what the
//            master put on the bus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_wb_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [9:0]  addr = 10'h0;
    logic [31:0] wdata = 32'h0;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        err;

    int checks = 0;
    int errors = 0;

    // Observations captured by run_access.
    int          acc_stb_cycles;
    int          acc_ack_count;
    int          acc_done_cycle;
    logic        acc_saw_cyc;
    logic        acc_busy;
    logic        acc_err;
    logic [31:0] acc_rdata;
    logic [3:0]  acc_sel;
    logic [31:0] acc_data;
    logic [9:0]  acc_addr;
    logic        acc_we;

    lsu_wb_master_if #(.ADDR_WIDTH(10)) wb ();

    lsu_wb_master #(.ADDR_WIDTH(10)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_req    (req),
        .i_we     (we),
        .i_funct3 (funct3),
        .i_addr   (addr),
        .i_wdata  (wdata),
        .o_busy   (busy),
        .o_done   (done),
        .o_rdata  (rdata),
        .o_err    (err),
        .wb       (wb)
    );

    always #5 clk = ~clk;

    // Issue one request at the current negedge (cycle 0) and play responder
    // until o_done is seen; acc_done_cycle stays -1 if it never comes.
    task automatic run_access(input logic a_we, input logic [2:0] a_f3,
                              input logic [9:0] a_addr, input logic [31:0] a_wdata,
                              input logic [31:0] a_bus, input int a_stall,
                              input logic a_ack_in_strobe);
        int stall_left;
        stall_left     = a_stall;
        acc_stb_cycles = 0;
        acc_ack_count  = 0;
        acc_done_cycle = -1;
        acc_saw_cyc    = 1'b0;
        acc_busy       = 1'b0;
        acc_err        = 1'b0;
        acc_sel        = 4'h0;
        acc_data       = 32'h0;
        acc_addr       = 10'h0;
        acc_we         = 1'b0;
        req    = 1'b1;
        we     = a_we;
        funct3 = a_f3;
        addr   = a_addr;
        wdata  = a_wdata;
        wb.i_wb_data = a_bus;
        @(negedge clk);
        req = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            if (done) begin
                acc_done_cycle = c;
                acc_err        = err;
                acc_rdata      = rdata;
                break;
            end
            if (busy) acc_busy = 1'b1;
            if (wb.o_wb_cyc) acc_saw_cyc = 1'b1;
            wb.i_wb_ack   = 1'b0;
            wb.i_wb_stall = 1'b0;
            if (wb.o_wb_stb) begin
                acc_stb_cycles++;
                acc_sel  = wb.o_wb_sel;
                acc_data = wb.o_wb_data;
                acc_addr = wb.o_wb_addr;
                acc_we   = wb.o_wb_we;
                if (stall_left > 0) begin
                    wb.i_wb_stall = 1'b1;
                    stall_left--;
                end else if (a_ack_in_strobe) begin
                    wb.i_wb_ack = 1'b1;
                    acc_ack_count++;
                end
            end else if (wb.o_wb_cyc) begin
                wb.i_wb_ack = 1'b1;
                acc_ack_count++;
            end
            @(negedge clk);
        end
        wb.i_wb_ack   = 1'b0;
        wb.i_wb_stall = 1'b0;
    endtask

    task automatic test_reset;
        wb.i_wb_ack = 1'b0; wb.i_wb_stall = 1'b0; wb.i_wb_data = 32'h0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
        checks++; if (wb.o_wb_cyc !== 1'b0 || wb.o_wb_stb !== 1'b0 || wb.o_wb_we !== 1'b0) begin
            errors++; $display("FAIL reset_cyc_stb_we: got %b%b%b expected 000", wb.o_wb_cyc, wb.o_wb_stb, wb.o_wb_we); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 00000000", rdata); end
        checks++; if (wb.o_wb_data !== 32'h0 || wb.o_wb_addr !== 10'h0 || wb.o_wb_sel !== 4'h0) begin
            errors++; $display("FAIL reset_bus: got data %h addr %h sel %b expected zeros", wb.o_wb_data, wb.o_wb_addr, wb.o_wb_sel); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_store_word;
        run_access(1'b1, 3'b010, 10'h008, 32'hDEADBEEF, 32'h0, 0, 1'b0);
        checks++; if (acc_sel !== 4'b1111) begin errors++; $display("FAIL sw_sel: got %b expected 1111", acc_sel); end
        checks++; if (acc_we !== 1'b1) begin errors++; $display("FAIL sw_we: got %b expected 1", acc_we); end
        checks++; if (acc_addr !== 10'h008) begin errors++; $display("FAIL sw_addr: got %h expected 008", acc_addr); end
        checks++; if (acc_data !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_data: got %h expected deadbeef", acc_data); end
        checks++; if (acc_done_cycle !== 3) begin errors++; $display("FAIL sw_done_cycle: got %0d expected 3", acc_done_cycle); end
        checks++; if (acc_busy !== 1'b1) begin errors++; $display("FAIL sw_busy: got %b expected 1", acc_busy); end
    endtask

    // Loads against the word 0x80FF7F01 held at 0x010.
    logic [2:0]  lt_f3   [7] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b000, 3'b011};
    logic [9:0]  lt_addr [7] = '{10'h013, 10'h013, 10'h012, 10'h010, 10'h011, 10'h012, 10'h010};
    logic [31:0] lt_exp  [7] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00007F01,
                                 32'h0000007F, 32'hFFFFFFFF, 32'h80FF7F01};
    logic [3:0]  lt_sel  [7] = '{4'b1000, 4'b1000, 4'b1100, 4'b0011, 4'b0010, 4'b0100, 4'b1111};

    task automatic test_load_extract;
        run_access(1'b1, 3'b010, 10'h010, 32'h80FF7F01, 32'h0, 0, 1'b0);
        checks++; if (acc_sel !== 4'b1111 || acc_data !== 32'h80FF7F01) begin
            errors++; $display("FAIL setup_store: got sel %b data %h expected 1111 80ff7f01", acc_sel, acc_data); end
        for (int i = 0; i < 7; i++) begin
            run_access(1'b0, lt_f3[i], lt_addr[i], 32'hFFFFFFFF, 32'h80FF7F01, 0, 1'b0);
            checks++; if (acc_rdata !== lt_exp[i]) begin errors++; $display("FAIL load_rdata[%0d]: got %h expected %h", i, acc_rdata, lt_exp[i]); end
            checks++; if (acc_sel !== lt_sel[i]) begin errors++; $display("FAIL load_sel[%0d]: got %b expected %b", i, acc_sel, lt_sel[i]); end
            checks++; if (acc_we !== 1'b0 || acc_data !== 32'h0 || acc_addr !== 10'h010) begin
                errors++; $display("FAIL load_bus[%0d]: got we %b data %h addr %h expected 0 00000000 010", i, acc_we, acc_data, acc_addr); end
            checks++; if (acc_done_cycle !== 3) begin errors++; $display("FAIL load_done_cycle[%0d]: got %0d expected 3", i, acc_done_cycle); end
        end
    endtask

    task automatic test_store_byte_half;
        run_access(1'b1, 3'b000, 10'h005, 32'h000000AB, 32'h0, 0, 1'b0);
        checks++; if (acc_sel !== 4'b0010) begin errors++; $display("FAIL sb_sel: got %b expected 0010", acc_sel); end
        checks++; if (acc_data !== 32'hABABABAB) begin errors++; $display("FAIL sb_data: got %h expected abababab", acc_data); end
        checks++; if (acc_addr !== 10'h004) begin errors++; $display("FAIL sb_addr: got %h expected 004", acc_addr); end
        run_access(1'b1, 3'b001, 10'h006, 32'h00001234, 32'h0, 0, 1'b0);
        checks++; if (acc_sel !== 4'b1100 || acc_data !== 32'h12341234) begin
            errors++; $display("FAIL sh_lanes: got sel %b data %h expected 1100 12341234", acc_sel, acc_data); end
        checks++; if (acc_rdata !== 32'h80FF7F01) begin errors++; $display("FAIL store_keeps_rdata: got %h expected 80ff7f01", acc_rdata); end
    endtask

    task automatic test_stall;
        run_access(1'b0, 3'b010, 10'h040, 32'h0, 32'hCAFEF00D, 3, 1'b0);
        checks++; if (acc_stb_cycles !== 4) begin errors++; $display("FAIL stall_stb_cycles: got %0d expected 4", acc_stb_cycles); end
        checks++; if (acc_ack_count !== 1) begin errors++; $display("FAIL stall_acks: got %0d expected 1", acc_ack_count); end
        checks++; if (acc_done_cycle !== 6) begin errors++; $display("FAIL stall_done_cycle: got %0d expected 6", acc_done_cycle); end
        checks++; if (acc_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL stall_rdata: got %h expected cafef00d", acc_rdata); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL stall_single_done: got %b expected 0", done); end
        checks++; if (rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL rdata_hold: got %h expected cafef00d", rdata); end
    endtask

    task automatic test_ack_in_strobe;
        run_access(1'b1, 3'b010, 10'h044, 32'h01020304, 32'h0, 0, 1'b1);
        checks++; if (acc_done_cycle !== 2) begin errors++; $display("FAIL strobe_ack_done_cycle: got %0d expected 2", acc_done_cycle); end
        checks++; if (acc_stb_cycles !== 1) begin errors++; $display("FAIL strobe_ack_stb_cycles: got %0d expected 1", acc_stb_cycles); end
        checks++; if (acc_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL strobe_ack_rdata: got %h expected cafef00d", acc_rdata); end
    endtask

    task automatic test_ack_idle_ignored;
        wb.i_wb_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (done !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL idle_ack[%0d]: got done %b busy %b expected 0 0", i, done, busy); end
        end
        wb.i_wb_ack = 1'b0;
    endtask

    task automatic test_back_to_back;
        run_access(1'b0, 3'b100, 10'h001, 32'h0, 32'h0000AA00, 0, 1'b0);
        checks++; if (acc_rdata !== 32'h000000AA) begin errors++; $display("FAIL b2b_first_rdata: got %h expected 000000aa", acc_rdata); end
        run_access(1'b1, 3'b001, 10'h002, 32'h00005555, 32'h0, 0, 1'b0);
        checks++; if (acc_done_cycle !== 3) begin errors++; $display("FAIL b2b_second_done_cycle: got %0d expected 3", acc_done_cycle); end
        checks++; if (acc_sel !== 4'b1100 || acc_data !== 32'h55555555 || acc_addr !== 10'h000) begin
            errors++; $display("FAIL b2b_second_bus: got sel %b data %h addr %h expected 1100 55555555 000", acc_sel, acc_data, acc_addr); end
        checks++; if (acc_rdata !== 32'h000000AA) begin errors++; $display("FAIL b2b_rdata_kept: got %h expected 000000aa", acc_rdata); end
    endtask

    task automatic test_misalign;
        run_access(1'b0, 3'b010, 10'h006, 32'h0, 32'h76543210, 0, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
        checks++; if (acc_err !== 1'b1) begin errors++; $display("FAIL lw_mis_err: got %b expected 1", acc_err); end
        checks++; if (acc_saw_cyc !== 1'b0) begin errors++; $display("FAIL lw_mis_cyc: got %b expected 0", acc_saw_cyc); end
        checks++; if (acc_done_cycle !== 1) begin errors++; $display("FAIL lw_mis_done_cycle: got %0d expected 1", acc_done_cycle); end
        checks++; if (acc_rdata !== 32'h000000AA) begin errors++; $display("FAIL lw_mis_rdata: got %h expected 000000aa", acc_rdata); end
`else
        checks++; if (acc_err !== 1'b0) begin errors++; $display("FAIL lw_mis_err: got %b expected 0", acc_err); end
        checks++; if (acc_addr !== 10'h004 || acc_sel !== 4'b1111) begin
            errors++; $display("FAIL lw_mis_bus: got addr %h sel %b expected 004 1111", acc_addr, acc_sel); end
        checks++; if (acc_done_cycle !== 3) begin errors++; $display("FAIL lw_mis_done_cycle: got %0d expected 3", acc_done_cycle); end
        checks++; if (acc_rdata !== 32'h76543210) begin errors++; $display("FAIL lw_mis_rdata: got %h expected 76543210", acc_rdata); end
`endif
        run_access(1'b0, 3'b001, 10'h013, 32'h0, 32'h76543210, 0, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
        checks++; if (acc_err !== 1'b1 || acc_saw_cyc !== 1'b0) begin
            errors++; $display("FAIL lh_mis: got err %b cyc %b expected 1 0", acc_err, acc_saw_cyc); end
`else
        checks++; if (acc_sel !== 4'b1100 || acc_rdata !== 32'h00007654 || acc_err !== 1'b0) begin
            errors++; $display("FAIL lh_mis: got sel %b rdata %h err %b expected 1100 00007654 0", acc_sel, acc_rdata, acc_err); end
`endif
    endtask

    task automatic test_reset_mid;
        req = 1'b1; we = 1'b0; funct3 = 3'b010; addr = 10'h020; wb.i_wb_data = 32'h11111111;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        checks++; if (wb.o_wb_cyc !== 1'b1 || wb.o_wb_stb !== 1'b0) begin
            errors++; $display("FAIL mid_wait_state: got cyc %b stb %b expected 1 0", wb.o_wb_cyc, wb.o_wb_stb); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (wb.o_wb_cyc !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL mid_reset_immediate: got cyc %b busy %b expected 0 0", wb.o_wb_cyc, busy); end
        @(negedge clk);
        rst_n = 1'b1;
        wb.i_wb_ack = 1'b1;
        @(negedge clk);
        wb.i_wb_ack = 1'b0;
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL mid_late_ack: got done %b busy %b expected 0 0", done, busy); end
        @(negedge clk);
        checks++; if (done !== 1'b0 || rdata !== 32'h0) begin
            errors++; $display("FAIL mid_no_done: got done %b rdata %h expected 0 00000000", done, rdata); end
        run_access(1'b0, 3'b010, 10'h020, 32'h0, 32'h12345678, 0, 1'b0);
        checks++; if (acc_done_cycle !== 3 || acc_rdata !== 32'h12345678) begin
            errors++; $display("FAIL mid_recover: got cycle %0d rdata %h expected 3 12345678", acc_done_cycle, acc_rdata); end
    endtask

    initial begin
        wb.i_wb_ack   = 1'b0;
        wb.i_wb_stall = 1'b0;
        wb.i_wb_data  = 32'h0;
        test_reset();
        test_store_word();
        test_load_extract();
        test_store_byte_half();
        test_stall();
        test_ack_in_strobe();
        test_ack_idle_ignored();
        test_back_to_back();
        test_misalign();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
